// File: rtl/seg7_pkg.sv
// Shared constants and glyph decoding for the multi-digit 7-segment scan driver.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package seg7_pkg;

    // All segments dark (active-low).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        return GLYPH[h];
    endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Digit-slot prescaler: counts 0..CLK_DIV-1, flags the last count and the PWM on-window.
// Latency: tc/lit are combinational from the current count and bright.
// Backpressure: none; free-running counter.
//
// Ports: clk, rst (sync, active-high), bright (0..7), tc (pcnt == CLK_DIV-1),
//        lit (pcnt < (bright+1)*CLK_DIV/8). CLK_DIV must be a multiple of 8.
module seg7_prescaler #(
    parameter int CLK_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] bright,
    output logic       tc,
    output logic       lit
);

    localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OW   = PW + 1;
    localparam int STEP = CLK_DIV / 8;

    logic [PW-1:0] pcnt;
    logic [OW-1:0] on_time;

    always_comb begin
        // One extra bit so that bright = 7 (on_time = CLK_DIV) is representable.
        on_time = OW'((int'(bright) + 1) * STEP);
        tc      = (pcnt == PW'(CLK_DIV - 1));
        lit     = ({1'b0, pcnt} < on_time);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (tc) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered value, dp and PWM brightness.
// Latency: seg/dp/an/frame_tick registered, one cycle behind scan state; a load shows at the next frame.
// Backpressure: none; load is a one-cycle strobe that is always accepted.
//
// Ports: clk, rst (sync, active-high), value (4 bits per digit, digit 0 rightmost),
//        dp_in, load, bright -> seg {g..a}, dp, an (all active-low), frame_tick.
// Optional: define SEG7_LZB_EN for leading-zero blanking of digits 1..NUM_DIGITS-1.
import seg7_pkg::*;

module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic [2:0]              bright,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int             IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0]  LAST = IW'(NUM_DIGITS - 1);

    logic                    tc;
    logic                    lit;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [4*NUM_DIGITS-1:0] act_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    boundary;
    logic [3:0]              cur_hex;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   an_sel;

    seg7_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .bright (bright),
        .tc     (tc),
        .lit    (lit)
    );

`ifdef SEG7_LZB_EN
    // A digit is blanked when it and every more-significant digit are zero
    // with no decimal point; scanning from the top keeps this a running AND.
    logic run;
    always_comb begin
        blank = '0;
        run   = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run      = run && (act_val[4*k +: 4] == 4'h0) && !act_dp[k];
            blank[k] = run;
        end
    end
`else
    assign blank = '0;
`endif

    // Select the active digit's data and build the one-hot-low anode pattern.
    always_comb begin
        boundary  = tc && (idx == LAST);
        cur_hex   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_sel    = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_hex   = act_val[4*k +: 4];
                cur_dp    = act_dp[k];
                cur_blank = blank[k];
                an_sel[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            act_val    <= '0;
            act_dp     <= '0;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            if (tc) begin
                idx <= (idx == LAST) ? '0 : idx + 1'b1;
            end

            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
            end

            // A load coinciding with the boundary bypasses the pending buffer so
            // the newest value wins and the stale pending one is dropped.
            if (boundary) begin
                act_val <= load ? value : pend_val;
                act_dp  <= load ? dp_in : pend_dp;
            end

            frame_tick <= boundary;

            if (lit && !cur_blank) begin
                an  <= an_sel;
                seg <= hex2seg(cur_hex);
                dp  <= ~cur_dp;
            end else begin
                an  <= '1;
                seg <= SEG_OFF;
                dp  <= 1'b1;
            end
        end
    end

endmodule
